spi_byte_master: RTL and testbench

Mode-0 SPI master that serialises one byte per start request and captures the byte returned on MISO. It sits between the flash command sequencer and the flash pins, and its outputs are fully registered. SCLK frequency is set by a parameterised divider. Chip-select can be held low across bytes so the sequencer can build multi-byte commands: opcode, address, data.

---
 rtl/spi_byte_master.sv | 115 +++++++++++
 tb/tb_spi_byte_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_master.sv
// Mode-0 SPI byte master: one byte per start, MSB first, with optional chip-select hold
// across bytes. Every pin-facing output comes straight from a flop.
module spi_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       keep_cs,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int              PW      = $clog2(CLK_DIV) + 1;
  localparam logic [PW-1:0]   PH_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SCLK_HIGH, SCLK_LOW, DONE} state_t;

  state_t        state, next_state;
  logic [PW-1:0] phase_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    tx_shift;   // bit 7 goes straight to spi_mosi at acceptance
  logic [7:0]    rx_shift;
  logic          cs_hold;
  logic          phase_last, accept;

  logic       busy_d, done_d, sclk_d, cs_n_d, mosi_d;
  logic [7:0] rx_data_d;

  assign phase_last = (phase_cnt == PH_LAST);
  assign accept     = (state == IDLE) && start;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: default first so no path through the case can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (start)      next_state = CS_SETUP;
      CS_SETUP:  if (phase_last) next_state = SCLK_HIGH;
      SCLK_HIGH: if (phase_last) next_state = SCLK_LOW;
      SCLK_LOW:  if (phase_last) next_state = (bit_cnt == 3'd7) ? DONE : SCLK_HIGH;
      DONE:                      next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // Outputs are computed from next_state so their flops line up with the state flop.
  always_comb begin
    busy_d    = (next_state != IDLE);
    done_d    = (next_state == DONE);
    sclk_d    = (next_state == SCLK_HIGH);
    cs_n_d    = (next_state == IDLE) ? ~cs_hold : 1'b0;
    rx_data_d = (next_state == DONE) ? rx_shift : rx_data;
    mosi_d    = spi_mosi;
    if (accept)
      mosi_d = tx_data[7];
    else if (state == SCLK_HIGH && phase_last && bit_cnt != 3'd7)
      mosi_d = tx_shift[6];
    else if (state == DONE)
      mosi_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_data   <= 8'h00;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      phase_cnt <= '0;
      bit_cnt   <= 3'd0;
      tx_shift  <= 7'd0;
      rx_shift  <= 8'h00;
      cs_hold   <= 1'b0;
    end else begin
      busy     <= busy_d;
      done     <= done_d;
      rx_data  <= rx_data_d;
      spi_cs_n <= cs_n_d;
      spi_sclk <= sclk_d;
      spi_mosi <= mosi_d;

      if (next_state != state || state == IDLE) phase_cnt <= '0;
      else                                      phase_cnt <= phase_cnt + PW'(1);

      if (accept) begin
        tx_shift <= tx_data[6:0];
        cs_hold  <= keep_cs;
        bit_cnt  <= 3'd0;
      end

      // Falling SCLK edge: capture MISO and advance MOSI (except after the last bit).
      if (state == SCLK_HIGH && phase_last) begin
        rx_shift <= {rx_shift[6:0], spi_miso};
        if (bit_cnt != 3'd7) tx_shift <= {tx_shift[5:0], 1'b0};
      end

      if (state == SCLK_LOW && phase_last && bit_cnt != 3'd7)
        bit_cnt <= bit_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_spi_byte_master.sv
// Scoreboarded bench for spi_byte_master: a CLK_DIV=4 instance in MISO loopback and a
// CLK_DIV=1 instance with MISO held high.
module tb_spi_byte_master;

  typedef struct {
    logic [7:0] rx;    // expected rx_data on done
    logic [7:0] seq;   // expected MOSI bits seen at the 8 SCLK rising edges
    int         len;   // expected busy length in cycles
  } exp_t;

  exp_t q4[$], q1[$];
  exp_t e4, e1;
  int   n_checks = 0, n_fail = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start4, keep4, busy4, done4, cs4, sclk4, mosi4, miso4;
  logic [7:0] tx4, rx4;
  logic       start1, keep1, busy1, done1, cs1, sclk1, mosi1, miso1;
  logic [7:0] tx1, rx1;

  assign miso4 = mosi4;
  assign miso1 = 1'b1;

  spi_byte_master #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .start(start4), .tx_data(tx4), .keep_cs(keep4),
    .busy(busy4), .done(done4), .rx_data(rx4), .spi_cs_n(cs4),
    .spi_sclk(sclk4), .spi_mosi(mosi4), .spi_miso(miso4)
  );

  spi_byte_master #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .keep_cs(keep1),
    .busy(busy1), .done(done1), .rx_data(rx1), .spi_cs_n(cs1),
    .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: count busy cycles and SCLK rises, collect MOSI at each rise, check on done.
  int         bcnt4 = 0, rise4 = 0, ndone4 = 0, bcnt1 = 0, rise1 = 0, ndone1 = 0;
  logic [7:0] seq4 = 8'h00, seq1 = 8'h00;
  logic       psclk4 = 1'b0, psclk1 = 1'b0;

  always @(negedge clk) begin
    if (busy4) bcnt4++;
    if (sclk4 && !psclk4) begin rise4++; seq4 = {seq4[6:0], mosi4}; end
    psclk4 = sclk4;
    if (done4) begin
      ndone4++;
      check("sb4_pending", 32'(q4.size() != 0), 32'd1);
      if (q4.size() != 0) begin
        e4 = q4.pop_front();
        check("div4_rx_data", 32'(rx4), 32'(e4.rx));
        check("div4_mosi_seq", 32'(seq4), 32'(e4.seq));
        check("div4_busy_len", 32'(bcnt4), 32'(e4.len));
        check("div4_sclk_rises", 32'(rise4), 32'd8);
      end
    end
    if (!busy4) begin bcnt4 = 0; rise4 = 0; seq4 = 8'h00; end
  end

  always @(negedge clk) begin
    if (busy1) bcnt1++;
    if (sclk1 && !psclk1) begin rise1++; seq1 = {seq1[6:0], mosi1}; end
    psclk1 = sclk1;
    if (done1) begin
      ndone1++;
      check("sb1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("div1_rx_data", 32'(rx1), 32'(e1.rx));
        check("div1_mosi_seq", 32'(seq1), 32'(e1.seq));
        check("div1_busy_len", 32'(bcnt1), 32'(e1.len));
        check("div1_sclk_rises", 32'(rise1), 32'd8);
      end
    end
    if (!busy1) begin bcnt1 = 0; rise1 = 0; seq1 = 8'h00; end
  end

  // Present start for one edge, then scramble tx_data/keep_cs to prove they were latched.
  task automatic issue4(input logic [7:0] tx, input logic keep);
    @(negedge clk);
    start4 = 1'b1; tx4 = tx; keep4 = keep;
    @(posedge clk);
    #1 start4 = 1'b0; tx4 = ~tx; keep4 = ~keep;
  endtask

  // Wait (bounded) for done on the div4 instance, counting cycles with cs high / mosi high.
  task automatic run4(output int cs_hi, output int mosi_hi);
    logic seen = 1'b0;
    cs_hi = 0; mosi_hi = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cs_hi   += int'(cs4);
      mosi_hi += int'(mosi4);
      if (done4) begin seen = 1'b1; break; end
    end
    check("div4_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           cs_hi, mosi_hi, d0, rises;
    logic         seen, prev;
    logic [17:0]  sc;

    rst = 1'b1;
    start4 = 1'b0; tx4 = 8'h00; keep4 = 1'b0;
    start1 = 1'b0; tx1 = 8'h00; keep1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(cs4), 32'd1);
    check("rst_sclk", 32'(sclk4), 32'd0);
    check("rst_mosi", 32'(mosi4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_rx_data", 32'(rx4), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Loopback 0xA5 at CLK_DIV=4.
    q4.push_back('{rx: 8'hA5, seq: 8'hA5, len: 69});
    issue4(8'hA5, 1'b0);
    run4(cs_hi, mosi_hi);
    check("a5_cs_low_during", 32'(cs_hi), 32'd0);
    @(negedge clk);
    check("a5_busy_after", 32'(busy4), 32'd0);
    check("a5_done_after", 32'(done4), 32'd0);
    check("a5_cs_release", 32'(cs4), 32'd1);
    check("a5_mosi_idle", 32'(mosi4), 32'd0);

    // CLK_DIV=1, MISO high: SCLK pattern per busy cycle is setup 0, 8x(1,0), done 0.
    q1.push_back('{rx: 8'hFF, seq: 8'h3C, len: 18});
    @(negedge clk);
    start1 = 1'b1; tx1 = 8'h3C; keep1 = 1'b0;
    @(posedge clk);
    #1 start1 = 1'b0; tx1 = 8'h00;
    sc = '0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sc = {sc[16:0], sclk1};
      if (done1) begin seen = 1'b1; break; end
    end
    check("div1_done_seen", 32'(seen), 32'd1);
    check("div1_sclk_pattern", 32'(sc), 32'(18'b010101010101010100));
    @(negedge clk);
    check("div1_cs_release", 32'(cs1), 32'd1);

    // Ignored start: 0xFF pulsed mid-transfer of 0x00.
    d0 = ndone4;
    q4.push_back('{rx: 8'h00, seq: 8'h00, len: 69});
    issue4(8'h00, 1'b0);
    mosi_hi = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 9)  begin start4 = 1'b1; tx4 = 8'hFF; end
      if (i == 10) start4 = 1'b0;
      mosi_hi += int'(mosi4);
      if (done4) begin seen = 1'b1; break; end
    end
    check("ign_done_seen", 32'(seen), 32'd1);
    repeat (100) begin
      @(negedge clk);
      mosi_hi += int'(mosi4);
    end
    check("ign_mosi_zero", 32'(mosi_hi), 32'd0);
    check("ign_single_done", 32'(ndone4 - d0), 32'd1);
    check("ign_busy_idle", 32'(busy4), 32'd0);

    // keep_cs: 0x03 holds CS, 0x80 releases it.
    q4.push_back('{rx: 8'h03, seq: 8'h03, len: 69});
    issue4(8'h03, 1'b1);
    run4(cs_hi, mosi_hi);
    check("keep1_cs_low", 32'(cs_hi), 32'd0);
    @(negedge clk);
    check("keep_cs_held_idle", 32'(cs4), 32'd0);
    check("keep_busy_idle", 32'(busy4), 32'd0);
    q4.push_back('{rx: 8'h80, seq: 8'h80, len: 69});
    issue4(8'h80, 1'b0);
    check("keep2_cs_low_start", 32'(cs4), 32'd0);
    run4(cs_hi, mosi_hi);
    check("keep2_cs_low", 32'(cs_hi), 32'd0);
    @(negedge clk);
    check("keep2_cs_release", 32'(cs4), 32'd1);

    // Reset after the 3rd SCLK rising edge of an unscoreboarded 0xC3 transfer.
    d0 = ndone4;
    issue4(8'hC3, 1'b0);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sclk4 && !prev) rises++;
      prev = sclk4;
      if (rises == 3) break;
    end
    check("rstmid_third_rise", 32'(rises), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_cs_n", 32'(cs4), 32'd1);
    check("rstmid_sclk", 32'(sclk4), 32'd0);
    check("rstmid_busy", 32'(busy4), 32'd0);
    check("rstmid_rx_data", 32'(rx4), 32'd0);
    check("rstmid_done", 32'(done4), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid_no_done", 32'(ndone4 - d0), 32'd0);

    // Normal transfer after the aborted one.
    q4.push_back('{rx: 8'h5A, seq: 8'h5A, len: 69});
    issue4(8'h5A, 1'b0);
    run4(cs_hi, mosi_hi);
    repeat (3) @(negedge clk);
    check("final_q4_empty", 32'(q4.size()), 32'd0);
    check("final_q1_empty", 32'(q1.size()), 32'd0);
    check("final_rx_hold", 32'(rx4), 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
